// File: rtl/llm_data_arb.sv
// Single-port command arbiter for the data-control datapath: snoop > demand > prefetch
// with anti-starvation promotion. Optional BUSY watchdog selected at build time.
module llm_data_arb #(
  parameter int ADDR_W       = 48,
  parameter int PRIO_W       = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pf_en,
  input  logic              snp_valid,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              snp_ready,
  input  logic              dmd_valid,
  input  logic [ADDR_W-1:0] dmd_addr,
  input  logic [PRIO_W-1:0] dmd_prio,
  output logic              dmd_ready,
  input  logic              pf_valid,
  input  logic [ADDR_W-1:0] pf_addr,
  output logic              pf_ready,
  output logic              dc_valid,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [1:0]        dc_src,
  output logic [PRIO_W-1:0] dc_prio,
  input  logic              dc_ready,
  input  logic              dc_done,
  output logic              arb_busy,
  output logic              arb_timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_SNP  = 2'b01;
  localparam logic [1:0] SRC_DMD  = 2'b10;
  localparam logic [1:0] SRC_PF   = 2'b11;

  state_t state, state_nxt;
  logic [SW-1:0] dmd_starve, pf_starve;
  logic pf_cand;
  logic win_snp, win_dmd, win_pf, any_win;
  logic timeout_hit;

  // A starved demand outranks everything; a starved prefetch only jumps over demand.
  always_comb begin
    pf_cand = pf_valid && pf_en;
    win_snp = 1'b0;
    win_dmd = 1'b0;
    win_pf  = 1'b0;
    if (dmd_valid && (dmd_starve == STARVE_MAX))
      win_dmd = 1'b1;
    else if (snp_valid)
      win_snp = 1'b1;
    else if (pf_cand && (pf_starve == STARVE_MAX))
      win_pf = 1'b1;
    else if (dmd_valid)
      win_dmd = 1'b1;
    else if (pf_cand)
      win_pf = 1'b1;
    any_win = win_snp || win_dmd || win_pf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_win) state_nxt = GRANT;
      GRANT:   if (dc_ready) state_nxt = BUSY;
      BUSY:    if (dc_done || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready pulses are gated by rst_n so no accept is seen while reset is held.
  always_comb begin
    snp_ready = rst_n && (state == IDLE) && win_snp;
    dmd_ready = rst_n && (state == IDLE) && win_dmd;
    pf_ready  = rst_n && (state == IDLE) && win_pf;
    dc_valid  = (state == GRANT);
    arb_busy  = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_addr <= '0;
      dc_src  <= SRC_NONE;
      dc_prio <= '0;
    end else if (state == IDLE) begin
      if (win_snp) begin
        dc_addr <= snp_addr;
        dc_src  <= SRC_SNP;
        dc_prio <= '0;
      end else if (win_dmd) begin
        dc_addr <= dmd_addr;
        dc_src  <= SRC_DMD;
        dc_prio <= dmd_prio;
      end else if (win_pf) begin
        dc_addr <= pf_addr;
        dc_src  <= SRC_PF;
        dc_prio <= '0;
      end
    end else if ((state == BUSY) && (state_nxt == IDLE)) begin
      dc_src <= SRC_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmd_starve <= '0;
      pf_starve  <= '0;
    end else begin
      if (state == IDLE) begin
        if (win_dmd)
          dmd_starve <= '0;
        else if (dmd_valid && (dmd_starve != STARVE_MAX))
          dmd_starve <= dmd_starve + 1'b1;
      end
      if (!pf_en)
        pf_starve <= '0;
      else if (state == IDLE) begin
        if (win_pf)
          pf_starve <= '0;
        else if (pf_cand && (pf_starve != STARVE_MAX))
          pf_starve <= pf_starve + 1'b1;
      end
    end
  end

`ifdef LLM_DATA_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt;
  logic          to_flag;

  // A dc_done arriving in the final watchdog cycle still counts as a normal completion.
  assign timeout_hit = (state == BUSY) && !dc_done && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign arb_timeout = to_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == GRANT)
        to_cnt <= '0;
      else if (state == BUSY)
        to_cnt <= to_cnt + 1'b1;
      if (timeout_hit)
        to_flag <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_llm_data_arb.sv
// Directed scoreboard bench for llm_data_arb: grant order, starvation promotion,
// prefetch enable, stalled grant, reset abort and the BUSY watchdog when built in.
module tb_llm_data_arb;

  localparam int ADDR_W = 48;
  localparam int PRIO_W = 2;
  localparam int STARVE_LIMIT = 8;
  localparam int TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pf_en;
  logic              snp_valid, dmd_valid, pf_valid;
  logic [ADDR_W-1:0] snp_addr, dmd_addr, pf_addr;
  logic [PRIO_W-1:0] dmd_prio;
  logic              snp_ready, dmd_ready, pf_ready;
  logic              dc_valid;
  logic [ADDR_W-1:0] dc_addr;
  logic [1:0]        dc_src;
  logic [PRIO_W-1:0] dc_prio;
  logic              dc_ready, dc_done;
  logic              arb_busy, arb_timeout;

  typedef struct {
    logic [1:0]        src;
    logic [ADDR_W-1:0] addr;
    logic [PRIO_W-1:0] prio;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  llm_data_arb #(
    .ADDR_W(ADDR_W), .PRIO_W(PRIO_W), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pf_en(pf_en),
    .snp_valid(snp_valid), .snp_addr(snp_addr), .snp_ready(snp_ready),
    .dmd_valid(dmd_valid), .dmd_addr(dmd_addr), .dmd_prio(dmd_prio), .dmd_ready(dmd_ready),
    .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_ready(pf_ready),
    .dc_valid(dc_valid), .dc_addr(dc_addr), .dc_src(dc_src), .dc_prio(dc_prio),
    .dc_ready(dc_ready), .dc_done(dc_done),
    .arb_busy(arb_busy), .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] simulation watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise a request and record the grant it should eventually produce.
  task automatic apply_stimulus(input logic [1:0] src, input logic [ADDR_W-1:0] addr,
                                input logic [PRIO_W-1:0] prio);
    exp_t e;
    e.src  = src;
    e.addr = addr;
    e.prio = (src == 2'b10) ? prio : '0;
    case (src)
      2'b01: begin snp_valid = 1'b1; snp_addr = addr; end
      2'b10: begin dmd_valid = 1'b1; dmd_addr = addr; dmd_prio = prio; end
      default: begin pf_valid = 1'b1; pf_addr = addr; end
    endcase
    sb.push_back(e);
  endtask

  // Waits for the next accept, compares it with the scoreboard head and walks the
  // command through GRANT (holding dc_ready low for 'hold' cycles) into BUSY.
  task automatic check_output(input int budget, input bit drop, input int hold, input bit finish);
    int n;
    exp_t e;
    logic [2:0] exp_rdy;
    n = 0;
    #1;
    while (!(snp_ready || dmd_ready || pf_ready) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() == 0) begin
      check("sb_underflow", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    exp_rdy = (e.src == 2'b01) ? 3'b100 : (e.src == 2'b10) ? 3'b010 : 3'b001;
    check("ready_onehot", {snp_ready, dmd_ready, pf_ready}, exp_rdy);
    if (!(snp_ready || dmd_ready || pf_ready)) return;
    @(negedge clk); #1;
    if (drop) begin
      case (e.src)
        2'b01: snp_valid = 1'b0;
        2'b10: dmd_valid = 1'b0;
        default: pf_valid = 1'b0;
      endcase
    end
    for (int k = 0; k <= hold; k++) begin
      check("grant_valid", dc_valid, 1'b1);
      check("grant_src", dc_src, e.src);
      check("grant_addr", dc_addr, e.addr);
      check("grant_prio", dc_prio, e.prio);
      if (k < hold) begin
        dc_done = 1'b1;
        @(negedge clk); #1;
      end
    end
    dc_done  = 1'b0;
    dc_ready = 1'b1;
    @(negedge clk); #1;
    dc_ready = 1'b0;
    check("busy_valid", dc_valid, 1'b0);
    check("busy_flag", arb_busy, 1'b1);
    if (!finish) return;
    dc_done = 1'b1;
    @(negedge clk); #1;
    dc_done = 1'b0;
    check("done_src", dc_src, 2'b00);
    check("done_busy", arb_busy, 1'b0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; pf_en = 1'b0;
    snp_valid = 1'b0; dmd_valid = 1'b0; pf_valid = 1'b0;
    snp_addr = '0; dmd_addr = '0; pf_addr = '0; dmd_prio = '0;
    dc_ready = 1'b0; dc_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_dc_valid", dc_valid, 1'b0);
    check("rst_dc_src", dc_src, 2'b00);
    check("rst_dc_addr", dc_addr, 48'h0);
    check("rst_dc_prio", dc_prio, 2'b00);
    check("rst_busy", arb_busy, 1'b0);
    check("rst_timeout", arb_timeout, 1'b0);
    check("rst_readies", {snp_ready, dmd_ready, pf_ready}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] simultaneous snp/dmd/pf");
    pf_en = 1'b1;
    apply_stimulus(2'b01, 48'hA1_0000_0001, 2'b00);
    apply_stimulus(2'b10, 48'hA2_0000_0002, 2'b10);
    apply_stimulus(2'b11, 48'hA3_0000_0003, 2'b00);
    repeat (3) check_output(3, 1'b1, 0, 1'b1);

    $display("[TB] stalled grant with spurious dc_done");
    apply_stimulus(2'b10, 48'h1000, 2'b11);
    check_output(3, 1'b1, 5, 1'b1);

    $display("[TB] demand starvation under continuous snoop");
    for (int i = 0; i < STARVE_LIMIT; i++) apply_stimulus(2'b01, 48'hB1_0000, 2'b00);
    apply_stimulus(2'b10, 48'hB2_0000, 2'b01);
    apply_stimulus(2'b01, 48'hB1_0000, 2'b00);
    apply_stimulus(2'b10, 48'hB2_0000, 2'b01);
    for (int i = 0; i < STARVE_LIMIT + 1; i++) check_output(3, 1'b0, 0, 1'b1);
    check_output(3, 1'b1, 0, 1'b1);
    check_output(3, 1'b1, 0, 1'b1);

    $display("[TB] prefetch gated by pf_en");
    pf_en = 1'b0;
    pf_valid = 1'b1;
    pf_addr = 48'hC0FFEE;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (pf_ready !== 1'b0 || dc_valid !== 1'b0) bad++;
    end
    check("pf_blocked_cycles", 64'(bad), 64'd0);
    @(negedge clk);
    pf_en = 1'b1;
    apply_stimulus(2'b11, 48'hC0FFEE, 2'b00);
    check_output(0, 1'b0, 0, 1'b0);
    pf_en = 1'b0;
    dc_done = 1'b1;
    @(negedge clk); #1;
    dc_done = 1'b0;
    check("pf_midflight_done_src", dc_src, 2'b00);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (pf_ready !== 1'b0 || dc_valid !== 1'b0) bad++;
    end
    check("pf_off_after_flight", 64'(bad), 64'd0);
    pf_valid = 1'b0;
    pf_en = 1'b1;

    $display("[TB] reset while BUSY");
    apply_stimulus(2'b10, 48'h2222, 2'b01);
    check_output(3, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstb_dc_valid", dc_valid, 1'b0);
    check("rstb_dc_src", dc_src, 2'b00);
    check("rstb_dc_addr", dc_addr, 48'h0);
    check("rstb_dc_prio", dc_prio, 2'b00);
    check("rstb_busy", arb_busy, 1'b0);
    check("rstb_dmd_ready", dmd_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(2'b10, 48'h2222, 2'b01);
    check_output(0, 1'b1, 0, 1'b1);

`ifdef LLM_DATA_ARB_TIMEOUT_EN
    $display("[TB] BUSY watchdog");
    apply_stimulus(2'b10, 48'h4444, 2'b01);
    check_output(3, 1'b1, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      if (arb_timeout !== 1'b0 || arb_busy !== 1'b1) bad++;
      @(negedge clk); #1;
    end
    check("to_busy_window", 64'(bad), 64'd0);
    check("to_flag", arb_timeout, 1'b1);
    check("to_idle", arb_busy, 1'b0);
    check("to_src", dc_src, 2'b00);
    dc_done = 1'b1;
    @(negedge clk); #1;
    dc_done = 1'b0;
    check("to_late_done", arb_busy, 1'b0);
    apply_stimulus(2'b01, 48'h5555, 2'b00);
    check_output(3, 1'b1, 0, 1'b1);
    check("to_sticky", arb_timeout, 1'b1);
`else
    $display("[TB] BUSY without watchdog");
    apply_stimulus(2'b10, 48'h4444, 2'b01);
    check_output(3, 1'b1, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (arb_timeout !== 1'b0 || arb_busy !== 1'b1) bad++;
    end
    check("nto_wait", 64'(bad), 64'd0);
    dc_done = 1'b1;
    @(negedge clk); #1;
    dc_done = 1'b0;
    check("nto_done_src", dc_src, 2'b00);
    check("nto_done_busy", arb_busy, 1'b0);
`endif

    check("sb_leftover", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
